// File: rtl/gemm_output_drain.sv
// gemm_output_drain
//   Snapshots the whole output-stationary PE mesh on a capture pulse, then
//   streams it out one mesh row per beat over valid/ready. Each element is
//   requantized on the way out: rounding arithmetic right shift (round half
//   toward +inf), then saturation to OutDataWidth.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   acc_i            PE accumulators, element r*MeshCol+c
//   capture_i        snapshot request, honored when capture_ready_o=1
//   capture_ready_o  high while idle
//   shift_i          right-shift amount, sampled at capture
//   data_o           requantized row, element c = column c
//   row_idx_o        row currently presented
//   valid_o          beat valid
//   last_o           high with the beat of row MeshRow-1
//   ready_i          consumer accepts the beat
//   done_o           one-cycle pulse after the last beat is accepted
module gemm_output_drain #(
    parameter int MeshRow      = 4,
    parameter int MeshCol      = 4,
    parameter int AccWidth     = 32,
    parameter int OutDataWidth = 8,
    parameter int ShiftWidth   = $clog2(AccWidth),
    parameter int RowW         = (MeshRow > 1) ? $clog2(MeshRow) : 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic [MeshRow*MeshCol-1:0][AccWidth-1:0]   acc_i,
    input  logic                                       capture_i,
    output logic                                       capture_ready_o,
    input  logic [ShiftWidth-1:0]                      shift_i,
    output logic [MeshCol-1:0][OutDataWidth-1:0]       data_o,
    output logic [RowW-1:0]                            row_idx_o,
    output logic                                       valid_o,
    output logic                                       last_o,
    input  logic                                       ready_i,
    output logic                                       done_o
);

    typedef enum logic {
        Idle,
        Drain
    } state_e;

    localparam logic [RowW-1:0]         LastRow = RowW'(MeshRow - 1);
    localparam logic signed [AccWidth:0] One    = {{AccWidth{1'b0}}, 1'b1};

    state_e                  state_q;
    logic                    valid_q;
    logic                    cap_rdy_q;
    logic                    done_q;
    logic [RowW-1:0]         row_cnt_q;
    logic [ShiftWidth-1:0]   shift_q;
    logic [AccWidth-1:0]     snap_q [MeshRow][MeshCol];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= Idle;
            valid_q   <= 1'b0;
            cap_rdy_q <= 1'b1;
            done_q    <= 1'b0;
            row_cnt_q <= '0;
            shift_q   <= '0;
            for (int unsigned r = 0; r < MeshRow; r++) begin
                for (int unsigned c = 0; c < MeshCol; c++) begin
                    snap_q[r][c] <= '0;
                end
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                Idle: begin
                    if (capture_i) begin
                        for (int unsigned r = 0; r < MeshRow; r++) begin
                            for (int unsigned c = 0; c < MeshCol; c++) begin
                                snap_q[r][c] <= acc_i[r*MeshCol + c];
                            end
                        end
                        shift_q   <= shift_i;
                        row_cnt_q <= '0;
                        state_q   <= Drain;
                        valid_q   <= 1'b1;
                        cap_rdy_q <= 1'b0;
                    end
                end
                Drain: begin
                    if (ready_i) begin
                        if (row_cnt_q == LastRow) begin
                            state_q   <= Idle;
                            valid_q   <= 1'b0;
                            cap_rdy_q <= 1'b1;
                            done_q    <= 1'b1;
                            row_cnt_q <= '0;
                        end else begin
                            row_cnt_q <= row_cnt_q + RowW'(1);
                        end
                    end
                end
                default: state_q <= Idle;
            endcase
        end
    end

    assign valid_o         = valid_q;
    assign capture_ready_o = cap_rdy_q;
    assign done_o          = done_q;
    assign row_idx_o       = row_cnt_q;
    assign last_o          = valid_q && (row_cnt_q == LastRow);

    for (genvar c = 0; c < MeshCol; c++) begin : g_col
        logic signed [AccWidth:0]     xe;
        logic signed [AccWidth:0]     bias;
        logic signed [AccWidth:0]     rnd;
        logic signed [AccWidth:0]     shd;
        logic        [OutDataWidth-1:0] y;

        // One extra bit of headroom keeps the rounding add from overflowing.
        always_comb begin
            xe   = {snap_q[row_cnt_q][c][AccWidth-1], snap_q[row_cnt_q][c]};
            bias = '0;
            if (shift_q != '0) begin
                bias = One << (shift_q - ShiftWidth'(1));
            end
            rnd = xe + bias;
            shd = rnd >>> shift_q;
        end

        if (OutDataWidth >= AccWidth) begin : g_ext
            assign y = OutDataWidth'(shd);
        end else begin : g_sat
            localparam logic signed [AccWidth:0] OutMax =
                {{(AccWidth-OutDataWidth+2){1'b0}}, {(OutDataWidth-1){1'b1}}};
            localparam logic signed [AccWidth:0] OutMin =
                {{(AccWidth-OutDataWidth+2){1'b1}}, {(OutDataWidth-1){1'b0}}};

            always_comb begin
                if (shd > OutMax) begin
                    y = OutMax[OutDataWidth-1:0];
                end else if (shd < OutMin) begin
                    y = OutMin[OutDataWidth-1:0];
                end else begin
                    y = shd[OutDataWidth-1:0];
                end
            end
        end

        assign data_o[c] = valid_q ? y : '0;
    end

endmodule
